// File: rtl/i2c_read_word16.sv
// I2C master that reads one 16-bit register: START, addr+W, pointer, repeated START,
// addr+R, two data bytes (ACK then NACK), STOP. Every bus phase advances one PT_CK.
module i2c_read_word16 (
    input  logic        RESET_N,
    input  logic        PT_CK,
    input  logic        GO,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic [7:0]  POINTER,
    input  logic        SDAI,
    output logic        SDAO,
    output logic        SCLO,
    output logic [15:0] RDATA16,
    output logic        END_OK,
    output logic        ACK_OK
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LAUNCH, S_START, S_BIT, S_RSTART, S_STOP, S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  phase;
    logic [1:0]  seq_cnt;
    logic [3:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic        nack;
    logic [15:0] shadow;

    logic [7:0]  tx_byte;
    logic        tx_bit;
    logic        is_rx;
    logic        nack_now;

    always_comb begin
        case (byte_idx)
            3'd0:    tx_byte = {SLAVE_ADDRESS[7:1], 1'b0};
            3'd1:    tx_byte = POINTER;
            3'd2:    tx_byte = {SLAVE_ADDRESS[7:1], 1'b1};
            default: tx_byte = 8'hFF;  // receive bytes: data bits released
        endcase
    end

    assign is_rx    = (byte_idx >= 3'd3);
    // 9th bit: released for slave ACK, driven low only as the master ACK of byte 3
    assign tx_bit   = bit_cnt[3] ? (byte_idx != 3'd3) : tx_byte[3'd7 - bit_cnt[2:0]];
    assign nack_now = nack | (!is_rx & SDAI);

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            SDAO     <= 1'b1;
            SCLO     <= 1'b1;
            END_OK   <= 1'b1;
            ACK_OK   <= 1'b0;
            RDATA16  <= 16'h0000;
            phase    <= 2'd0;
            seq_cnt  <= 2'd0;
            bit_cnt  <= 4'd0;
            byte_idx <= 3'd0;
            nack     <= 1'b0;
            shadow   <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    SDAO   <= 1'b1;
                    SCLO   <= 1'b1;
                    END_OK <= 1'b1;
                    if (GO) state <= S_ARM;
                end
                S_ARM: begin
                    if (!GO) state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    END_OK   <= 1'b0;
                    ACK_OK   <= 1'b0;
                    nack     <= 1'b0;
                    byte_idx <= 3'd0;
                    bit_cnt  <= 4'd0;
                    phase    <= 2'd0;
                    state    <= S_START;
                end
                S_START: begin
                    SDAO  <= 1'b0;
                    SCLO  <= 1'b1;
                    state <= S_BIT;
                end
                S_BIT: begin
                    phase <= phase + 2'd1;
                    case (phase)
                        2'd0: SCLO <= 1'b0;
                        2'd1: SDAO <= tx_bit;
                        2'd2: SCLO <= 1'b1;
                        default: begin
                            // SCL is still high going into this edge, so SDAI is the settled bit
                            SCLO <= 1'b0;
                            if (bit_cnt[3]) begin
                                nack    <= nack_now;
                                bit_cnt <= 4'd0;
                                seq_cnt <= 2'd0;
                                if (!is_rx && nack_now)
                                    state <= S_STOP;
                                else if (byte_idx == 3'd1) begin
                                    state    <= S_RSTART;
                                    byte_idx <= 3'd2;
                                end else if (byte_idx == 3'd4)
                                    state <= S_STOP;
                                else
                                    byte_idx <= byte_idx + 3'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                if (is_rx) shadow <= {shadow[14:0], SDAI};
                            end
                        end
                    endcase
                end
                S_RSTART: begin
                    seq_cnt <= seq_cnt + 2'd1;
                    case (seq_cnt)
                        2'd0: begin SDAO <= 1'b1; SCLO <= 1'b0; end
                        2'd1: begin SDAO <= 1'b1; SCLO <= 1'b1; end
                        default: begin
                            SDAO  <= 1'b0;
                            SCLO  <= 1'b1;
                            phase <= 2'd0;
                            state <= S_BIT;
                        end
                    endcase
                end
                S_STOP: begin
                    seq_cnt <= seq_cnt + 2'd1;
                    case (seq_cnt)
                        2'd0: begin SDAO <= 1'b0; SCLO <= 1'b0; end
                        2'd1: begin SDAO <= 1'b0; SCLO <= 1'b1; end
                        default: begin
                            SDAO  <= 1'b1;
                            SCLO  <= 1'b1;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_DONE: begin
                    END_OK <= 1'b1;
                    if (!nack) begin
                        ACK_OK  <= 1'b1;
                        RDATA16 <= shadow;
                    end
                    state <= GO ? S_ARM : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_read_word16.md
Name: i2c_read_word16

Overview:
- I2C master that reads one 16-bit register from a slave, MSB first.
- Transaction: START, address+W, pointer byte, repeated START, address+R, two data bytes (master ACK after MSB, NACK after LSB), STOP.
- Read-side companion to the power-monitor word writer. Shares its bus and bit-timing scheme: PT_CK is the slow I2C phase tick and every bus phase advances one PT_CK.

Parameters:
- none. Timing is set entirely by the PT_CK rate.

Ports:
- RESET_N  in  1  Asynchronous, active-low reset.
- PT_CK  in  1  I2C phase tick clock. All logic runs on its rising edge.
- GO  in  1  Level request. A transaction is launched when GO is seen low after having been seen high.
- SLAVE_ADDRESS  in  8  7-bit address in [7:1]; bit0 is ignored and replaced by R/W.
- POINTER  in  8  Register pointer to read.
- SDAI  in  1  SDA line input.
- SDAO  out  1  SDA drive (1 = release).
- SCLO  out  1  SCL drive (1 = release).
- RDATA16  out  16  Last successfully read word.
- END_OK  out  1  1 = idle/done, 0 = transaction in progress.
- ACK_OK  out  1  1 = last transaction received all three slave ACKs.

Behaviour:
- Reset (async, any state): state=IDLE, SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, RDATA16=0, internal counters=0.
- IDLE: SDAO=1, SCLO=1, END_OK=1. GO=1 -> ARM.
- ARM: hold all outputs. GO=0 -> LAUNCH.
- LAUNCH (1 tick): END_OK<=0, ACK_OK<=0, clear nack flag, byte index=0 -> START.
- START (1 tick): SDAO=0, SCLO=1.
- Byte transfer: 9 bits, each bit exactly 4 ticks:
  - P0: SCLO=0.
  - P1: SDAO=bit value.
  - P2: SCLO=1.
  - P3: SCLO=0. SDAI is registered in this tick, capturing the value present while SCL is high. Bit counter increments.
- Transmit bytes, MSB first:
  - Byte 0 = {SLAVE_ADDRESS[7:1],0}.
  - Byte 1 = POINTER.
  - Byte 2 = {SLAVE_ADDRESS[7:1],1}.
  - 9th bit: SDAO=1 (released). SDAI sampled as slave ACK; SDAI=1 sets the nack flag.
- Receive bytes (byte 3 = RDATA[15:8], byte 4 = RDATA[7:0]):
  - Bits 1-8: SDAO=1, SDAI shifted into a shadow register MSB first.
  - 9th bit: SDAO=0 (master ACK) for byte 3; SDAO=1 (master NACK) for byte 4.
- After byte 0, 1 or 2 completes: if nack flag set -> STOP (abort). Otherwise byte 1 -> RSTART, and the other bytes proceed to the next byte.
- RSTART (3 ticks): (SDAO,SCLO) = 1,0 then 1,1 then 0,1. Then byte 2.
- STOP (3 ticks): (SDAO,SCLO) = 0,0 then 0,1 then 1,1.
- DONE (1 tick): END_OK<=1.
  - If nack flag clear: ACK_OK<=1 and RDATA16<=shadow.
  - Else: ACK_OK stays 0 and RDATA16 is unchanged.
  - Next state: IDLE if GO=0, ARM if GO=1.
- Latency:
  - Successful read: END_OK is 0 for exactly 188 ticks (LAUNCH tick through the last STOP tick); DONE is the 189th tick.
  - Abort after byte 0: END_OK is 0 for 1+1+36+3 = 41 ticks.
- GO held high never launches a transaction. GO toggling while END_OK=0 is ignored; the request is re-evaluated only in IDLE/ARM.
- RDATA16 is stable throughout a transaction and updates only in DONE.
- No clock stretching. SDAI is not sampled outside the ACK and receive bits.
- Reset mid-transaction: outputs return to reset values immediately. No STOP is generated; the bus is released (SDAO=SCLO=1).

Test Plan:
- Address 0x80, pointer 0x02, slave model ACKs and returns 0xA55A: SDAO bytes are 0x80, 0x02, 0x81; data bits are released; master ACK=0 then NACK=1; RDATA16=0xA55A; ACK_OK=1; END_OK low 188 ticks.
- Slave NACKs the address byte: STOP follows immediately; ACK_OK=0; RDATA16 keeps its prior value (0xA55A); END_OK low 41 ticks.
- Slave NACKs the pointer byte only: abort after byte 1 with no RSTART; ACK_OK=0.
- GO held high 500 ticks: no SCLO activity. GO falls: START (SDAO=0, SCLO=1) appears 2 ticks after GO=0 is sampled.
- RESET_N pulsed low during byte 3: SDAO=1, SCLO=1, END_OK=1, RDATA16=0, ACK_OK=0 asynchronously. The next GO pulse completes a full read normally.
- Back-to-back reads 0x1234 then 0xFFFF with GO re-pulsed after END_OK rises: both words are captured correctly, and RSTART shows SDA falling while SCL is high.
